// File: rtl/cordic_pkg.sv
// Shared types and frame geometry for the CORDIC result serializer.
// CORDIC_SER_HDR_EN adds a one-byte sequence header to every frame.
package cordic_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    localparam int MAG_TX_W = 16;
    localparam int PHASE_W  = 32;
    localparam int ENTRY_W  = MAG_TX_W + PHASE_W;
    localparam logic [3:0] HDR_MAGIC = 4'hA;

`ifdef CORDIC_SER_HDR_EN
    localparam int FRAME_BYTES = 7;
`else
    localparam int FRAME_BYTES = 6;
`endif

    localparam int FRAME_W = FRAME_BYTES * 8;
    localparam int IDX_W   = 3;

endpackage

// File: rtl/cordic_res_fifo.sv
// Small synchronous FIFO with a combinational head read, so a pop can load
// the serializer on the same edge it is requested.
module cordic_res_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [AW:0]       diff;

    // A push while full is only legal together with a pop: the slot being
    // overwritten is the head, which has already been read out this cycle.
    always_ff @(posedge clk) begin
        if (ena && push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (ena) begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign diff  = wr_ptr_reg - rd_ptr_reg;
    assign count = CW'(diff);
    assign rdata = mem_reg[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (diff == (AW + 1)'(DEPTH));

endmodule

// File: rtl/cordic_result_serializer.sv
// Queues CORDIC (magnitude, phase) results and streams them out as
// little-endian byte frames; CORDIC_SER_HDR_EN prefixes a {A, seq} header.
module cordic_result_serializer
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       res_valid,
    input  logic [WIDTH-1:0]           res_mag,
    input  logic [31:0]                res_phase,
    input  logic                       clr_ovf,
    output logic [7:0]                 byte_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    ser_state_e          state_reg, state_next;
    logic [FRAME_W-1:0]  shift_reg, shift_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [7:0]          byte_out_reg, byte_out_next;
    logic                out_valid_reg, out_valid_next;
    logic                overflow_reg, overflow_next;

    logic                push, pop, load, drop;
    logic                fifo_full, fifo_empty;
    logic [MAG_TX_W-1:0] mag_ext;
    logic [ENTRY_W-1:0]  head;
    logic [FRAME_W-1:0]  load_word;
    logic                fire, last_byte;

    assign mag_ext = MAG_TX_W'($signed(res_mag));

    cordic_res_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .push  (push),
        .pop   (pop),
        .wdata ({mag_ext, res_phase}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

`ifdef CORDIC_SER_HDR_EN
    logic [3:0] seq_reg, seq_next;

    // The sequence number only advances once the header byte is actually taken.
    always_comb begin
        seq_next = seq_reg;
        if (ena && state_reg == S_SEND && fire && idx_reg == '0) begin
            seq_next = seq_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= '0;
        end else begin
            seq_reg <= seq_next;
        end
    end

    assign load_word = {head[PHASE_W-1:0], head[ENTRY_W-1:PHASE_W], HDR_MAGIC, seq_reg};
`else
    assign load_word = {head[PHASE_W-1:0], head[ENTRY_W-1:PHASE_W]};
`endif

    assign fire      = out_valid_reg && out_ready;
    assign last_byte = (idx_reg == IDX_W'(FRAME_BYTES - 1));

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        idx_next       = idx_reg;
        byte_out_next  = byte_out_reg;
        out_valid_next = out_valid_reg;
        overflow_next  = overflow_reg;
        load           = 1'b0;
        pop            = 1'b0;
        push           = 1'b0;
        drop           = 1'b0;

        if (ena) begin
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (!last_byte) begin
                            byte_out_next = shift_reg[7:0];
                            shift_next    = shift_reg >> 8;
                            idx_next      = idx_reg + 1'b1;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next     = S_IDLE;
                            out_valid_next = 1'b0;
                            byte_out_next  = '0;
                            idx_next       = '0;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase

            // Byte 0 goes straight to the output; the shift register keeps the rest.
            if (load) begin
                pop            = 1'b1;
                shift_next     = load_word >> 8;
                byte_out_next  = load_word[7:0];
                idx_next       = '0;
                out_valid_next = 1'b1;
                state_next     = S_SEND;
            end

            push = res_valid && (!fifo_full || pop);
            drop = res_valid && fifo_full && !pop;

            if (drop) begin
                overflow_next = 1'b1;
            end else if (clr_ovf) begin
                overflow_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            shift_reg     <= '0;
            idx_reg       <= '0;
            byte_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            idx_reg       <= idx_next;
            byte_out_reg  <= byte_out_next;
            out_valid_reg <= out_valid_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign byte_out  = byte_out_reg;
    assign out_valid = out_valid_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Directed bench for cordic_result_serializer: table-driven single frames
// plus hand-written overflow, back-to-back, ena, reset and WIDTH=12 sequences.
module tb_cordic_result_serializer;
    import cordic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ena, res_valid, clr_ovf, out_ready;
    logic [15:0] res_mag;
    logic [31:0] res_phase;
    logic [7:0]  byte_out;
    logic        out_valid, overflow;
    logic [2:0]  level;

    logic        res_valid12, clr_ovf12, out_ready12;
    logic [11:0] res_mag12;
    logic [31:0] res_phase12;
    logic [7:0]  byte_out12;
    logic        out_valid12, overflow12;
    logic [2:0]  level12;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [3:0]  tb_seq = 4'd0;

    typedef struct {
        string       name;
        logic [15:0] mag;
        logic [31:0] phase;
        logic [47:0] tx;      // expected bytes, first transmitted in the top byte
        logic [31:0] rmask;   // out_ready pattern, bit n used on stream cycle n
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    cordic_result_serializer #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .res_valid(res_valid),
        .res_mag(res_mag), .res_phase(res_phase), .clr_ovf(clr_ovf),
        .byte_out(byte_out), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .level(level)
    );

    cordic_result_serializer #(.WIDTH(12), .DEPTH(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .res_valid(res_valid12),
        .res_mag(res_mag12), .res_phase(res_phase12), .clr_ovf(clr_ovf12),
        .byte_out(byte_out12), .out_valid(out_valid12), .out_ready(out_ready12),
        .overflow(overflow12), .level(level12)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_frame_tx(input logic [47:0] tx);
`ifdef CORDIC_SER_HDR_EN
        exp_q.push_back({4'hA, tb_seq});
        tb_seq = tb_seq + 4'd1;
`endif
        for (int k = 5; k >= 0; k--) begin
            exp_q.push_back(tx[k*8 +: 8]);
        end
    endfunction

    function automatic void add_frame(input logic [15:0] mag, input logic [31:0] ph);
        add_frame_tx({mag[7:0], mag[15:8], ph[7:0], ph[15:8], ph[23:16], ph[31:24]});
    endfunction

    // Called and returns aligned to a falling edge.
    task automatic push_one(input logic [15:0] mag, input logic [31:0] ph);
        res_valid = 1'b1;
        res_mag   = mag;
        res_phase = ph;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    // Drains exp_q from the main DUT under an out_ready pattern. When idx
    // reaches inject_at and that byte is accepted, a result 7 is pushed.
    task automatic run_stream(input string name, input logic [31:0] rmask, input int inject_at);
        int idx = 0;
        int gaps = 0;
        int cyc = 0;
        bit started = 0;
        logic rdy;
        while (idx < exp_q.size() && cyc < 400) begin
            rdy = rmask[cyc % 32];
            res_valid = 1'b0;
            if (out_valid) begin
                started = 1;
                check($sformatf("%s_byte%0d", name, idx), byte_out, exp_q[idx]);
                if (rdy) begin
                    if (idx == inject_at) begin
                        res_valid = 1'b1;
                        res_mag   = 16'h0007;
                        res_phase = 32'h07070707;
                    end
                    idx++;
                end
            end else if (started) begin
                gaps++;
            end
            out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        res_valid = 1'b0;
        check($sformatf("%s_count", name), idx, exp_q.size());
        check($sformatf("%s_gaps", name), gaps, 0);
        check($sformatf("%s_idle", name), out_valid, 1'b0);
    endtask

    initial begin
        tbl[0] = '{"single",  16'h1234, 32'hA1B2C3D4, 48'h3412D4C3B2A1, 32'hFFFFFFFF};
        tbl[1] = '{"bkpress", 16'h1234, 32'hA1B2C3D4, 48'h3412D4C3B2A1, 32'h99999999};
        tbl[2] = '{"negmag",  16'hFFFF, 32'h80000000, 48'hFFFF00000080, 32'h55555555};
        tbl[3] = '{"minmag",  16'h8000, 32'h7FFFFFFF, 48'h0080FFFFFF7F, 32'hFFFFFFFF};
        tbl[4] = '{"mixed",   16'h00A5, 32'h12345678, 48'hA50078563412, 32'h33333333};

        rst_n = 1'b0; ena = 1'b1; res_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        res_mag = '0; res_phase = '0;
        res_valid12 = 1'b0; clr_ovf12 = 1'b0; out_ready12 = 1'b0; res_mag12 = '0; res_phase12 = '0;
        repeat (2) @(negedge clk);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_level", level, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            add_frame_tx(tbl[v].tx);
            push_one(tbl[v].mag, tbl[v].phase);
            check({tbl[v].name, "_latency"}, out_valid, 1'b0);
            run_stream(tbl[v].name, tbl[v].rmask, -1);
            check({tbl[v].name, "_level"}, level, 3'd0);
        end

        // Overflow: one frame in the serializer, four queued, sixth dropped.
        exp_q.delete();
        for (int i = 1; i <= 6; i++) begin
            res_valid = 1'b1;
            res_mag   = 16'(i);
            res_phase = 32'h01010101 * i;
            if (i <= 5) add_frame(16'(i), 32'h01010101 * i);
            @(negedge clk);
            if (i == 5) begin
                check("ovf_full_no_drop", overflow, 1'b0);
                check("ovf_level_full", level, 3'd4);
            end
        end
        res_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", level, 3'd4);
        res_valid = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        res_valid = 1'b0; clr_ovf = 1'b0;
        check("ovf_drop_beats_clr", overflow, 1'b1);
        check("ovf_level_after_drop", level, 3'd4);
        add_frame(16'h0007, 32'h07070707);
        run_stream("ovf_drain", 32'hFFFFFFFF, FRAME_BYTES - 1);
        check("ovf_drain_level", level, 3'd0);
        check("ovf_still_set", overflow, 1'b1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Back-to-back frames: no idle cycle between them.
        exp_q.delete();
        push_one(16'h1111, 32'h22222222);
        push_one(16'hABCD, 32'h01234567);
        push_one(16'h0F0F, 32'hDEADBEEF);
        add_frame(16'h1111, 32'h22222222);
        add_frame(16'hABCD, 32'h01234567);
        add_frame(16'h0F0F, 32'hDEADBEEF);
        check("b2b_level", level, 3'd2);
        run_stream("b2b", 32'hFFFFFFFF, -1);

        // ena low mid-frame: outputs hold, out_ready and res_valid ignored.
        exp_q.delete();
        add_frame(16'h5A5A, 32'h0F0F0F0F);
        push_one(16'h5A5A, 32'h0F0F0F0F);
        @(negedge clk);
        ena = 1'b0; out_ready = 1'b1; res_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ena_hold_valid", out_valid, 1'b1);
            check("ena_hold_byte", byte_out, exp_q[0]);
            check("ena_hold_level", level, 3'd0);
        end
        ena = 1'b1; res_valid = 1'b0; out_ready = 1'b0;
        run_stream("ena_resume", 32'hFFFFFFFF, -1);

        // Asynchronous reset mid-frame with two results queued.
        push_one(16'h0101, 32'h01010101);
        push_one(16'h0202, 32'h02020202);
        push_one(16'h0303, 32'h03030303);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("rstmid_level_before", level, 3'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_level", level, 3'd0);
        check("rstmid_byte_out", byte_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rstmid_no_bytes", seen, 0);
        end
        out_ready = 1'b0;
        tb_seq = 4'd0;
        exp_q.delete();
        add_frame(16'hC0DE, 32'hFACEB00C);
        push_one(16'hC0DE, 32'hFACEB00C);
        run_stream("post_rst_a", 32'hFFFFFFFF, -1);
        exp_q.delete();
        add_frame(16'h0042, 32'h00000001);
        push_one(16'h0042, 32'h00000001);
        run_stream("post_rst_b", 32'hFFFFFFFF, -1);

        // WIDTH=12 instance: 12'hF80 must be sign-extended to 16'hFF80.
        res_valid12 = 1'b1; res_mag12 = 12'hF80; res_phase12 = 32'h0;
        @(negedge clk);
        res_valid12 = 1'b0;
        @(negedge clk);
        check("w12_valid", out_valid12, 1'b1);
`ifdef CORDIC_SER_HDR_EN
        check("w12_hdr", byte_out12, 8'hA0);
        out_ready12 = 1'b1;
        @(negedge clk);
`endif
        check("w12_byte0", byte_out12, 8'h80);
        out_ready12 = 1'b1;
        @(negedge clk);
        check("w12_byte1", byte_out12, 8'hFF);
        repeat (5) @(negedge clk);
        out_ready12 = 1'b0;
        check("w12_idle", out_valid12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
